// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 arrow-key sequencer.
// Arrow keys appear only in their E0-extended form.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;

  typedef logic [1:0] key_t;

  localparam key_t KEY_LEFT  = 2'd0;
  localparam key_t KEY_DOWN  = 2'd1;
  localparam key_t KEY_RIGHT = 2'd2;
  localparam key_t KEY_UP    = 2'd3;

  // 'release' is a reserved word, so the flag is named rel.
  typedef struct packed {
    logic rel;
    key_t key;
  } evt_t;

  function automatic logic is_arrow(input logic [7:0] b);
    return (b == SC_LEFT) || (b == SC_DOWN) || (b == SC_RIGHT) || (b == SC_UP);
  endfunction

  function automatic key_t to_key(input logic [7:0] b);
    key_t k;
    k = KEY_LEFT;
    case (b)
      SC_DOWN:  k = KEY_DOWN;
      SC_RIGHT: k = KEY_RIGHT;
      SC_UP:    k = KEY_UP;
      default:  k = KEY_LEFT;
    endcase
    return k;
  endfunction

  // held is ordered {up,left,down,right}, which is not the key numbering.
  function automatic logic [1:0] held_idx(input key_t k);
    logic [1:0] i;
    i = 2'd0;
    case (k)
      KEY_LEFT:  i = 2'd2;
      KEY_DOWN:  i = 2'd1;
      KEY_RIGHT: i = 2'd0;
      default:   i = 2'd3;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small synchronous event FIFO; push while full is accepted only alongside a pop.
// The head reads as zero whenever the FIFO is empty.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/ps2_arrow_key_sequencer.sv
// Turns a raw PS/2 byte stream into arrow press/release events plus a held-key vector.
// Typematic repeats are filtered against held; stale prefixes are dropped by a timeout.
module ps2_arrow_key_sequencer
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic [3:0] held,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_data,
  output logic       overflow,
  output logic       timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_held;
  logic [3:0]    w_held_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_to_err;
  logic          w_to_fire;
  logic          r_ovf;
  logic          w_push;
  evt_t          w_evt;
  key_t          w_key;
  logic [1:0]    w_hi;
  logic          w_arrow;
  logic          w_full;
  logic          w_empty;

  assign w_key   = to_key(in_byte);
  assign w_hi    = held_idx(w_key);
  assign w_arrow = is_arrow(in_byte);

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_push      = 1'b0;
    w_evt       = '0;
    w_cnt_nxt   = '0;
    w_to_fire   = 1'b0;
    if (in_valid) begin
      case (r_state)
        IDLE: begin
          if (in_byte == SC_EXT)      w_state_nxt = EXT;
          else if (in_byte == SC_BRK) w_state_nxt = BRK;
          else                        w_state_nxt = IDLE;
        end
        EXT: begin
          if (in_byte == SC_BRK)      w_state_nxt = EXT_BRK;
          else if (in_byte == SC_EXT) w_state_nxt = EXT;
          else begin
            w_state_nxt = IDLE;
            if (w_arrow && !r_held[w_hi]) begin
              w_held_nxt[w_hi] = 1'b1;
              w_push           = 1'b1;
              w_evt            = '{rel: 1'b0, key: w_key};
            end
          end
        end
        EXT_BRK: begin
          w_state_nxt = IDLE;
          if (w_arrow && r_held[w_hi]) begin
            w_held_nxt[w_hi] = 1'b0;
            w_push           = 1'b1;
            w_evt            = '{rel: 1'b1, key: w_key};
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE) begin
      // A byte arriving in the expiry cycle takes the branch above instead.
      if (r_cnt == TO_MAX) begin
        w_state_nxt = IDLE;
        w_to_fire   = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state  <= IDLE;
      r_held   <= '0;
      r_cnt    <= '0;
      r_to_err <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_held   <= w_held_nxt;
      r_cnt    <= w_cnt_nxt;
      r_to_err <= w_to_fire;
      // Full implies non-empty, so a ready consumer always frees a slot.
      if (w_push && w_full && !evt_ready) r_ovf <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk      (clk),
    .areset_n (areset_n),
    .i_push   (w_push),
    .i_data   (w_evt),
    .i_pop    (evt_ready),
    .o_data   (evt_data),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign evt_valid   = ~w_empty;
  assign held        = r_held;
  assign overflow    = r_ovf;
  assign timeout_err = r_to_err;

endmodule
